// File: rtl/pcie_cfg_mgmt_pkg.sv
// Shared types and widths for the PCIe configuration-management bridge.
//   state_e             : bridge FSM states (idle / access in flight / response pending)
//   CFG_MGMT_*_WIDTH    : widths of the hard-IP management bus fields
package pcie_cfg_mgmt_pkg;

  localparam int unsigned CFG_MGMT_ADDR_WIDTH = 10;
  localparam int unsigned CFG_MGMT_FUNC_WIDTH = 8;
  localparam int unsigned CFG_MGMT_DATA_WIDTH = 32;
  localparam int unsigned CFG_MGMT_BE_WIDTH   = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/pcie_cfg_mgmt_if.sv
// Bridges a valid/ready request/response pair onto the PCIe hard-IP cfg_mgmt port.
// One access is outstanding at a time; every output is a flop.
//
// Optional feature: define PCIE_CFG_MGMT_TIMEOUT_EN to abort an access that receives no
// cfg_mgmt_read_write_done within 2^TIMEOUT_WIDTH-1 cycles (response flagged with m_rsp_error).
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   s_req_*                          : request (addr/func/write/data/be, valid/ready)
//   m_rsp_*                          : response (data/error, valid/ready)
//   cfg_mgmt_* outputs               : hard-IP management request, strobe held until done
//   cfg_mgmt_read_data / _write_done : hard-IP management completion
module pcie_cfg_mgmt_if
  import pcie_cfg_mgmt_pkg::*;
#(
  parameter int unsigned                    TIMEOUT_WIDTH = 10,
  parameter logic [CFG_MGMT_DATA_WIDTH-1:0] TIMEOUT_DATA  = 32'hFFFF_FFFF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CFG_MGMT_ADDR_WIDTH-1:0] s_req_addr,
  input  logic [CFG_MGMT_FUNC_WIDTH-1:0] s_req_func,
  input  logic                           s_req_write,
  input  logic [CFG_MGMT_DATA_WIDTH-1:0] s_req_data,
  input  logic [CFG_MGMT_BE_WIDTH-1:0]   s_req_be,
  input  logic                           s_req_valid,
  output logic                           s_req_ready,
  output logic [CFG_MGMT_DATA_WIDTH-1:0] m_rsp_data,
  output logic                           m_rsp_error,
  output logic                           m_rsp_valid,
  input  logic                           m_rsp_ready,
  output logic [CFG_MGMT_ADDR_WIDTH-1:0] cfg_mgmt_addr,
  output logic [CFG_MGMT_FUNC_WIDTH-1:0] cfg_mgmt_function_number,
  output logic                           cfg_mgmt_write,
  output logic [CFG_MGMT_DATA_WIDTH-1:0] cfg_mgmt_write_data,
  output logic [CFG_MGMT_BE_WIDTH-1:0]   cfg_mgmt_byte_enable,
  output logic                           cfg_mgmt_read,
  input  logic [CFG_MGMT_DATA_WIDTH-1:0] cfg_mgmt_read_data,
  input  logic                           cfg_mgmt_read_write_done
);

  state_e r_state, w_state_d;

  logic                           r_req_ready,  w_req_ready_d;
  logic [CFG_MGMT_DATA_WIDTH-1:0] r_rsp_data,   w_rsp_data_d;
  logic                           r_rsp_error,  w_rsp_error_d;
  logic                           r_rsp_valid,  w_rsp_valid_d;
  logic [CFG_MGMT_ADDR_WIDTH-1:0] r_addr,       w_addr_d;
  logic [CFG_MGMT_FUNC_WIDTH-1:0] r_func,       w_func_d;
  logic                           r_write,      w_write_d;
  logic [CFG_MGMT_DATA_WIDTH-1:0] r_wdata,      w_wdata_d;
  logic [CFG_MGMT_BE_WIDTH-1:0]   r_be,         w_be_d;
  logic                           r_read,       w_read_d;

  logic w_accept;
  logic w_done;
  logic w_timeout;
  logic w_finish;

  // r_req_ready is the registered copy of "next state is idle", so it already gates acceptance.
  assign w_accept = (r_state == StIdle) && s_req_valid && r_req_ready;
  // Completions outside ACCESS are dropped here.
  assign w_done   = (r_state == StAccess) && cfg_mgmt_read_write_done;
  assign w_finish = w_done || w_timeout;

`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
  // Fires in the cycle the count would reach all-ones, i.e. the 2^W-1'th ACCESS cycle.
  assign w_timeout = (r_state == StAccess) && (w_cnt_inc == {TIMEOUT_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == StAccess) begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = ^{TIMEOUT_DATA, (TIMEOUT_WIDTH == 0)};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept)    w_state_d = StAccess;
      StAccess: if (w_finish)    w_state_d = StResp;
      StResp:   if (m_rsp_ready) w_state_d = StIdle;
      default:                   w_state_d = StIdle;
    endcase
  end

  // Output next-values; every output is registered below.
  always_comb begin
    w_req_ready_d = (w_state_d == StIdle);
    w_rsp_valid_d = (w_state_d == StResp);
    w_rsp_data_d  = r_rsp_data;
    w_rsp_error_d = r_rsp_error;
    w_addr_d      = r_addr;
    w_func_d      = r_func;
    w_write_d     = r_write;
    w_wdata_d     = r_wdata;
    w_be_d        = r_be;
    w_read_d      = r_read;

    if (w_accept) begin
      w_addr_d  = s_req_addr;
      w_func_d  = s_req_func;
      w_wdata_d = s_req_data;
      w_be_d    = s_req_be;
      w_write_d = s_req_write;
      w_read_d  = !s_req_write;
    end else if (w_finish) begin
      w_read_d  = 1'b0;
      w_write_d = 1'b0;
      if (w_done) begin
        // Done beats a simultaneous timeout.
        w_rsp_data_d  = r_read ? cfg_mgmt_read_data : '0;
        w_rsp_error_d = 1'b0;
      end else begin
        w_rsp_data_d  = r_read ? TIMEOUT_DATA : '0;
        w_rsp_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_addr      <= '0;
      r_func      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_read      <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_error <= w_rsp_error_d;
      r_addr      <= w_addr_d;
      r_func      <= w_func_d;
      r_write     <= w_write_d;
      r_wdata     <= w_wdata_d;
      r_be        <= w_be_d;
      r_read      <= w_read_d;
    end
  end

  assign s_req_ready              = r_req_ready;
  assign m_rsp_valid              = r_rsp_valid;
  assign m_rsp_data               = r_rsp_data;
  assign m_rsp_error              = r_rsp_error;
  assign cfg_mgmt_addr            = r_addr;
  assign cfg_mgmt_function_number = r_func;
  assign cfg_mgmt_write           = r_write;
  assign cfg_mgmt_write_data      = r_wdata;
  assign cfg_mgmt_byte_enable     = r_be;
  assign cfg_mgmt_read            = r_read;

endmodule
